// File: rtl/c_tile_drain.sv
// c_tile_drain: egress DMA that reads the C result tile from BRAM and streams it to the host.
// Define C_TILE_DRAIN_STALL_EN to build the backpressure stall counter on stall_cycles.
module c_tile_drain #(
    parameter  int W     = 32,
    parameter  int DEPTH = 64,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_drain,
    input  logic [AW:0]   count,
    output logic          bram_re,
    output logic [AW-1:0] bram_raddr,
    input  logic [W-1:0]  bram_rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          out_last,
    output logic          busy,
    output logic          drain_done,
    output logic [31:0]   stall_cycles
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);

    state_e state_q, state_d;

    logic [AW:0]  eff_count_q, eff_count_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         inflight_q, inflight_d;
    logic         inflight_last_q, inflight_last_d;
    logic [W-1:0] fifo_data_q [2];
    logic [W-1:0] fifo_data_d [2];
    logic [1:0]   fifo_last_q, fifo_last_d;
    logic         wr_idx_q, wr_idx_d;
    logic         rd_idx_q, rd_idx_d;
    logic [1:0]   occ_q, occ_d;

    logic         start_acc;
    logic         head_valid;
    logic         pop;
    logic         push;
    logic [2:0]   pending;
    logic         can_issue;

    assign start_acc  = (state_q == S_IDLE) && start_drain;
    assign head_valid = (occ_q != 2'd0);
    assign pop        = head_valid && out_ready;
    assign push       = inflight_q;

    // Entries that will occupy the FIFO after this edge, excluding a read issued now.
    assign pending   = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign can_issue = (rd_ptr_q < eff_count_q) && (pending < 3'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_drain) state_d = S_RUN;
            S_RUN:  if (pop && fifo_last_q[rd_idx_q]) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q == S_RUN);
        drain_done = (state_q == S_DONE);
        bram_re    = (state_q == S_RUN) && can_issue;
        bram_raddr = bram_re ? rd_ptr_q[AW-1:0] : '0;
        out_valid  = head_valid;
        out_data   = head_valid ? fifo_data_q[rd_idx_q] : '0;
        out_last   = head_valid ? fifo_last_q[rd_idx_q] : 1'b0;
    end

    always_comb begin
        eff_count_d     = eff_count_q;
        rd_ptr_d        = rd_ptr_q;
        inflight_d      = bram_re;
        inflight_last_d = bram_re && (rd_ptr_q == eff_count_q - ONE_C);
        fifo_data_d     = fifo_data_q;
        fifo_last_d     = fifo_last_q;
        wr_idx_d        = wr_idx_q;
        rd_idx_d        = rd_idx_q;
        occ_d           = occ_q;

        if (start_acc) begin
            eff_count_d = ((count == '0) || (count > DEPTH_C)) ? DEPTH_C : count;
            rd_ptr_d    = '0;
        end

        if (bram_re) begin
            rd_ptr_d = rd_ptr_q + ONE_C;
        end

        // Data returning from last cycle's read lands in the FIFO tail.
        if (push) begin
            fifo_data_d[wr_idx_q] = bram_rdata;
            fifo_last_d[wr_idx_q] = inflight_last_q;
            wr_idx_d              = ~wr_idx_q;
        end

        if (pop) begin
            rd_idx_d = ~rd_idx_q;
        end

        case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            eff_count_q     <= '0;
            rd_ptr_q        <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i] <= '0;
            end
            fifo_last_q     <= '0;
            wr_idx_q        <= 1'b0;
            rd_idx_q        <= 1'b0;
            occ_q           <= '0;
        end else begin
            eff_count_q     <= eff_count_d;
            rd_ptr_q        <= rd_ptr_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            fifo_data_q     <= fifo_data_d;
            fifo_last_q     <= fifo_last_d;
            wr_idx_q        <= wr_idx_d;
            rd_idx_q        <= rd_idx_d;
            occ_q           <= occ_d;
        end
    end

`ifdef C_TILE_DRAIN_STALL_EN
    logic [31:0] stall_q, stall_d;

    // Counts RUN cycles where the host holds off a valid beat; saturates, holds until next start.
    always_comb begin
        stall_d = stall_q;
        if (start_acc) begin
            stall_d = '0;
        end else if ((state_q == S_RUN) && head_valid && !out_ready &&
                     (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_c_tile_drain.sv
// Self-checking bench for c_tile_drain: BRAM model with 1-cycle latency, queue-based beat
// reference, directed drains with randomized tile contents and host backpressure.
module tb_c_tile_drain;

    localparam int W     = 32;
    localparam int DEPTH = 64;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst;
    logic          start_drain;
    logic [AW:0]   count;
    logic          bram_re;
    logic [AW-1:0] bram_raddr;
    logic [W-1:0]  bram_rdata = '0;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_last;
    logic          busy;
    logic          drain_done;
    logic [31:0]   stall_cycles;

    logic [W-1:0]  mem [DEPTH];
    logic [W-1:0]  expQ [$];

    int vectors     = 0;
    int miscompares = 0;

    c_tile_drain #(.W(W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_drain  (start_drain),
        .count        (count),
        .bram_re      (bram_re),
        .bram_raddr   (bram_raddr),
        .bram_rdata   (bram_rdata),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .busy         (busy),
        .drain_done   (drain_done),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    // C tile BRAM: synchronous read, data valid the cycle after bram_re.
    always @(posedge clk) begin
        if (bram_re) bram_rdata <= mem[bram_raddr];
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic start, input int cnt, input logic rstVal);
        logic [31:0] c;
        c           = cnt;
        start_drain = start;
        count       = c[AW:0];
        rst         = rstVal;
    endtask

    // Starts one drain and follows it cycle by cycle. mode: 0 ready=1, 1 toggling,
    // 2 random, 3 five stall cycles once valid rises. restartAt/resetAt pick a beat number.
    task automatic runDrain(input int cnt, input int mode, input int restartAt, input int resetAt,
                            output int beats, output int stalls,
                            output int firstValid, output int lastBeat);
        int eff, cycle, expAddr, outstanding, nextOut, stallLeft;
        bit prevStall, prevLast, doReset, doRestart, finished;
        logic [W-1:0] prevData;
        eff = (cnt == 0 || cnt > DEPTH) ? DEPTH : cnt;
        expQ.delete();
        for (int i = 0; i < eff; i++) expQ.push_back(mem[i]);
        beats = 0; stalls = 0; firstValid = -1; lastBeat = -1;
        expAddr = 0; outstanding = 0; stallLeft = 5;
        prevStall = 0; prevLast = 0; prevData = '0;
        doReset = 0; doRestart = 0; finished = 0;

        applyStimulus(1'b1, cnt, 1'b0);
        @(posedge clk); #1;
        start_drain = 1'b0;
        cycle = 1;
        while (!finished && cycle <= 400) begin
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = (cycle % 2 == 1);
                2: out_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (out_valid && stallLeft > 0) begin
                        out_ready = 1'b0;
                        stallLeft--;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
            start_drain = doRestart;
            doRestart   = 0;
            if (doReset) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                start_drain = 1'b0;
                @(negedge clk);
                checkOutput("rstValid", out_valid, 0);
                checkOutput("rstBusy", busy, 0);
                checkOutput("rstRe", bram_re, 0);
                checkOutput("rstDone", drain_done, 0);
                checkOutput("rstStall", stall_cycles, 0);
                expQ.delete();
                finished = 1;
            end else begin
                @(negedge clk);
                if (cycle == 1) begin
                    checkOutput("busyRise", busy, 1);
                    checkOutput("firstRe", bram_re, 1);
                end
                if (bram_re) begin
                    checkOutput("reInRun", busy, 1);
                    checkOutput("raddr", bram_raddr, expAddr);
                    expAddr++;
                end
                nextOut = outstanding + int'(bram_re) - int'(out_valid && out_ready);
                checkOutput("fifoBound", nextOut <= 2, 1);
                outstanding = nextOut;
                if (prevStall) begin
                    checkOutput("stallValid", out_valid, 1);
                    checkOutput("stallData", out_data, prevData);
                    checkOutput("stallLast", out_last, prevLast);
                end
                if (out_valid && firstValid < 0) firstValid = cycle;
                if (out_valid && !out_ready) stalls++;
                prevStall = out_valid && !out_ready;
                prevData  = out_data;
                prevLast  = out_last;
                if (out_valid && out_ready) begin
                    if (expQ.size() == 0) begin
                        checkOutput("beatCount", beats + 1, eff);
                    end else begin
                        checkOutput("data", out_data, expQ[0]);
                        checkOutput("last", out_last, expQ.size() == 1);
                        expQ.delete(0);
                    end
                    beats++;
                    lastBeat = cycle;
                    if (beats == restartAt) doRestart = 1;
                    if (beats == resetAt) doReset = 1;
                end
                if (drain_done) begin
                    checkOutput("doneBusy", busy, 0);
                    checkOutput("doneAfterLast", cycle, lastBeat + 1);
                    checkOutput("allBeats", beats, eff);
                    checkOutput("allReads", expAddr, eff);
                    @(posedge clk); #1;
                    @(negedge clk);
                    checkOutput("donePulse", drain_done, 0);
                    checkOutput("idleBusy", busy, 0);
                    checkOutput("idleRe", bram_re, 0);
`ifdef C_TILE_DRAIN_STALL_EN
                    checkOutput("stallCount", stall_cycles, stalls);
`else
                    checkOutput("stallTied", stall_cycles, 0);
`endif
                    finished = 1;
                end else begin
                    @(posedge clk); #1;
                    cycle++;
                end
            end
        end
        if (!finished) begin
            checkOutput("timeout", cycle, 400);
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
        end
    endtask

    initial begin
        int beats, stalls, firstValid, lastBeat;
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        applyStimulus(1'b0, 0, 1'b1);
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("resetValid", out_valid, 0);
        checkOutput("resetBusy", busy, 0);
        checkOutput("resetDone", drain_done, 0);
        checkOutput("resetRe", bram_re, 0);
        checkOutput("resetRaddr", bram_raddr, 0);
        checkOutput("resetData", out_data, 0);
        checkOutput("resetLast", out_last, 0);
        checkOutput("resetStall", stall_cycles, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        $display("[TB] contiguous drain of 4 words");
        for (int i = 0; i < 4; i++) mem[i] = 32'h10 + i;
        runDrain(4, 0, -1, -1, beats, stalls, firstValid, lastBeat);
        checkOutput("latencyFirst", firstValid, 3);
        checkOutput("noBubbles", lastBeat, 6);
        checkOutput("contigBeats", beats, 4);

        $display("[TB] backpressure drain of 8 words");
        for (int i = 0; i < 8; i++) mem[i] = 100 + i;
        runDrain(8, 1, -1, -1, beats, stalls, firstValid, lastBeat);
        checkOutput("bpBeats", beats, 8);

        $display("[TB] count edge cases");
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        runDrain(0, 2, -1, -1, beats, stalls, firstValid, lastBeat);
        checkOutput("count0Beats", beats, DEPTH);
        runDrain(DEPTH + 5, 0, -1, -1, beats, stalls, firstValid, lastBeat);
        checkOutput("countBigBeats", beats, DEPTH);

        $display("[TB] ignored start, then reset mid-drain");
        runDrain(8, 0, 2, -1, beats, stalls, firstValid, lastBeat);
        checkOutput("restartBeats", beats, 8);
        runDrain(8, 0, -1, 3, beats, stalls, firstValid, lastBeat);
        checkOutput("resetBeats", beats, 3);
        runDrain(2, 0, -1, -1, beats, stalls, firstValid, lastBeat);
        checkOutput("freshBeats", beats, 2);

        $display("[TB] single word with host stall");
        runDrain(1, 3, -1, -1, beats, stalls, firstValid, lastBeat);
        checkOutput("singleBeats", beats, 1);
        checkOutput("singleStalls", stalls, 5);
`ifdef C_TILE_DRAIN_STALL_EN
        checkOutput("singleStallCnt", stall_cycles, 5);
`else
        checkOutput("singleStallCnt", stall_cycles, 0);
`endif

        $display("[TB] randomized drains");
        for (int k = 0; k < 4; k++) begin
            int cnt;
            for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
            cnt = $urandom_range(1, DEPTH + 6);
            runDrain(cnt, 2, -1, -1, beats, stalls, firstValid, lastBeat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
